// File: rtl/frame_wr_sched.sv
// Frame write scheduler: merges luma/chroma decoder writes into one FIFO, drains it over a
// req/ack memory port, and pulses frame_done once every write of a frame has been retired.
module frame_wr_sched #(
    parameter int                DEPTH       = 16,
    parameter int                ADDR_W      = 21,
    parameter logic [ADDR_W-1:0] CHROMA_BASE = 21'h100000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   li_we_luma,
    input  logic                   li_we_chroma,
    input  logic [19:0]            li_addr_luma,
    input  logic [18:0]            li_addr_chroma,
    input  logic [31:0]            li_data,
    input  logic                   li_lastMB_DF,
    input  logic [15:0]            li_POC,
    output logic                   mo_req,
    output logic [ADDR_W-1:0]      mo_addr,
    output logic [31:0]            mo_data,
    input  logic                   mi_ack,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   frame_done,
    output logic [15:0]            frame_POC,
    output logic                   busy,
    output logic [2:0]             err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {S_RUN, S_DRAIN} state_t;

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [31:0]       r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]  r_level, r_cnt;
    logic [15:0]       r_pend, r_poc;
    logic              r_done, r_lastmb_d;
    logic [2:0]        r_err;
    state_t            r_state;

    logic              w_push_req, w_push, w_pop, w_full, w_rise, w_collide, w_overflow;
    logic [ADDR_W-1:0] w_push_addr;
    logic [LVL_W-1:0]  w_start_cnt, w_cnt_nxt;
    logic [15:0]       w_pend_nxt, w_poc_nxt;
    logic              w_done_nxt, w_frame_err;
    state_t            w_state_nxt;

    // Luma wins a collision; chroma lands in the upper region of the unified map.
    assign w_push_req  = li_we_luma | li_we_chroma;
    assign w_push_addr = li_we_luma ? ADDR_W'(li_addr_luma)
                                    : CHROMA_BASE + ADDR_W'(li_addr_chroma);
    assign w_full      = (r_level == LVL_W'(DEPTH));
    assign w_pop       = (r_level != '0) && mi_ack;
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_collide   = li_we_luma && li_we_chroma;
    assign w_overflow  = w_push_req && !w_push;
    assign w_rise      = li_lastMB_DF && !r_lastmb_d;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= w_push_addr;
            r_mem_data[r_wr_ptr] <= li_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_lastmb_d <= 1'b0;
            r_err      <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level    <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
            r_lastmb_d <= li_lastMB_DF;
            r_err      <= r_err | {w_frame_err, w_collide, w_overflow};
        end
    end

    // Frame tracking: snapshot the words belonging to this frame, count them out.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_poc_nxt   = r_poc;
        w_done_nxt  = 1'b0;
        w_frame_err = 1'b0;
        w_start_cnt = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
        case (r_state)
            S_RUN: begin
                if (w_rise) begin
                    w_pend_nxt = li_POC;
                    if (w_start_cnt == '0) begin
                        w_done_nxt = 1'b1;
                        w_poc_nxt  = li_POC;
                    end else begin
                        w_state_nxt = S_DRAIN;
                        w_cnt_nxt   = w_start_cnt;
                    end
                end
            end
            S_DRAIN: begin
                w_frame_err = w_rise;
                if (w_pop) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == LVL_W'(1)) begin
                        w_done_nxt  = 1'b1;
                        w_poc_nxt   = r_pend;
                        w_state_nxt = S_RUN;
                    end
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_poc   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_poc   <= w_poc_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Head entry is gated so the port reads zero whenever nothing is requested.
    assign mo_req     = (r_level != '0);
    assign mo_addr    = mo_req ? r_mem_addr[r_rd_ptr] : '0;
    assign mo_data    = mo_req ? r_mem_data[r_rd_ptr] : '0;
    assign fifo_level = r_level;
    assign frame_done = r_done;
    assign frame_POC  = r_poc;
    assign busy       = mo_req || (r_state == S_DRAIN);
    assign err        = r_err;

endmodule

// File: tb/tb_frame_wr_sched.sv
// Bench for frame_wr_sched: directed scenarios plus random traffic, compared each cycle
// against a queue-based reference of the scheduler's externally visible behaviour.
module tb_frame_wr_sched;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        li_we_luma = 1'b0, li_we_chroma = 1'b0, li_lastMB_DF = 1'b0, mi_ack = 1'b0;
    logic [19:0] li_addr_luma = '0;
    logic [18:0] li_addr_chroma = '0;
    logic [31:0] li_data = '0;
    logic [15:0] li_POC = '0;
    logic        mo_req, frame_done, busy;
    logic [20:0] mo_addr;
    logic [31:0] mo_data;
    logic [4:0]  fifo_level;
    logic [15:0] frame_POC;
    logic [2:0]  err;

    frame_wr_sched #(.DEPTH(DEPTH), .ADDR_W(21), .CHROMA_BASE(21'h100000)) dut (
        .clk(clk), .reset_n(reset_n),
        .li_we_luma(li_we_luma), .li_we_chroma(li_we_chroma),
        .li_addr_luma(li_addr_luma), .li_addr_chroma(li_addr_chroma),
        .li_data(li_data), .li_lastMB_DF(li_lastMB_DF), .li_POC(li_POC),
        .mo_req(mo_req), .mo_addr(mo_addr), .mo_data(mo_data), .mi_ack(mi_ack),
        .fifo_level(fifo_level), .frame_done(frame_done), .frame_POC(frame_POC),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [20:0] a; logic [31:0] d; } ent_t;

    ent_t        q[$];
    bit          m_drain, m_done, m_prev;
    int          m_cnt;
    logic [15:0] m_pend, m_poc;
    logic [2:0]  m_err;
    int          n_chk = 0, n_err = 0, done_seen = 0, ntx = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_drain = 0; m_done = 0; m_prev = 0; m_cnt = 0;
        m_pend = '0; m_poc = '0; m_err = '0;
    endtask

    // Reference: what the memory port must see, derived from the frame-level rules.
    task automatic model_edge();
        bit   pop, req, acc, rise;
        ent_t e;
        if (reset_n) begin
            pop  = (q.size() != 0) && mi_ack;
            req  = li_we_luma || li_we_chroma;
            acc  = req && (q.size() < DEPTH || pop);
            rise = li_lastMB_DF && !m_prev;
            e.a  = li_we_luma ? {1'b0, li_addr_luma} : 21'h100000 + {2'b00, li_addr_chroma};
            e.d  = li_data;
            if (li_we_luma && li_we_chroma) m_err[1] = 1'b1;
            if (req && !acc) m_err[0] = 1'b1;
            m_done = 0;
            if (m_drain) begin
                if (rise) m_err[2] = 1'b1;
                if (pop) begin
                    m_cnt--;
                    if (m_cnt == 0) begin m_done = 1; m_poc = m_pend; m_drain = 0; end
                end
            end else if (rise) begin
                m_cnt  = q.size() + int'(acc) - int'(pop);
                m_pend = li_POC;
                if (m_cnt == 0) begin m_done = 1; m_poc = li_POC; end
                else m_drain = 1;
            end
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
            m_prev = li_lastMB_DF;
        end
    endtask

    task automatic check_all();
        chk("mo_req", mo_req, q.size() != 0);
        if (q.size() != 0) begin
            chk("mo_addr", mo_addr, q[0].a);
            chk("mo_data", mo_data, q[0].d);
        end
        chk("fifo_level", fifo_level, q.size());
        chk("frame_done", frame_done, m_done);
        chk("frame_POC", frame_POC, m_poc);
        chk("busy", busy, (q.size() != 0) || m_drain);
        chk("err", err, m_err);
        if (frame_done) done_seen++;
    endtask

    task automatic step();
        if (mo_req && mi_ack && reset_n) ntx++;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic no_write();
        li_we_luma = 0; li_we_chroma = 0;
    endtask

    task automatic luma(input logic [19:0] a, input logic [31:0] d);
        li_we_luma = 1; li_we_chroma = 0; li_addr_luma = a; li_data = d;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("rst_addr", mo_addr, 0);
        chk("rst_data", mo_data, 0);
        reset_n = 1;

        // Single luma word with ack held high
        mi_ack = 1;
        luma(20'h00010, 32'hA5A5A5A5);
        step();
        no_write();
        chk("t1_addr", mo_addr, 21'h000010);
        chk("t1_data", mo_data, 32'hA5A5A5A5);
        step();
        chk("t1_req_low", mo_req, 0);
        chk("t1_level", fifo_level, 0);

        // Chroma mapping, then a collision
        mi_ack = 0;
        li_we_chroma = 1; li_addr_chroma = 19'h00003; li_data = 32'h12345678;
        step();
        no_write();
        chk("t2_chroma_addr", mo_addr, 21'h100003);
        mi_ack = 1;
        step();
        li_we_luma = 1; li_we_chroma = 1; li_addr_luma = 20'h00055; li_addr_chroma = 19'h7;
        li_data = 32'hCAFEF00D;
        step();
        no_write();
        chk("t2_collide_addr", mo_addr, 21'h000055);
        chk("t2_err", err, 3'b010);
        step();
        chk("t2_level", fifo_level, 0);

        // Overflow: 17 pushes against a stalled port, then 16 in-order transfers
        mi_ack = 0;
        for (int i = 0; i < 17; i++) begin
            luma(20'(i + 32'h100), 32'(i * 3 + 7));
            step();
        end
        no_write();
        chk("t3_level", fifo_level, 16);
        chk("t3_ovf", err[0], 1);
        mi_ack = 1;
        ntx = 0;
        for (int i = 0; i < 20; i++) step();
        chk("t3_transfers", ntx, 16);

        // Frame of 5 words, slow acknowledge
        mi_ack = 0;
        for (int i = 0; i < 5; i++) begin
            luma(20'(i + 32'h200), 32'(32'hF000 + i));
            step();
        end
        no_write();
        li_lastMB_DF = 1; li_POC = 16'd4;
        done_seen = 0;
        step();
        li_lastMB_DF = 0;
        step();
        for (int w = 0; w < 5; w++) begin
            mi_ack = 0;
            repeat (3) step();
            mi_ack = 1;
            step();
        end
        chk("t4_done", frame_done, 1);
        chk("t4_poc", frame_POC, 16'd4);
        chk("t4_busy", busy, 0);
        mi_ack = 0;
        step();
        chk("t4_done_once", done_seen, 1);

        // lastMB on an empty FIFO, then a second rise during drain
        li_lastMB_DF = 1; li_POC = 16'd9;
        step();
        chk("t5_done_empty", frame_done, 1);
        chk("t5_poc_empty", frame_POC, 16'd9);
        li_lastMB_DF = 0;
        step();
        for (int i = 0; i < 2; i++) begin
            luma(20'(i + 32'h300), 32'(i));
            step();
        end
        no_write();
        done_seen = 0;
        li_lastMB_DF = 1; li_POC = 16'd11;
        step();
        li_lastMB_DF = 0;
        step();
        li_lastMB_DF = 1; li_POC = 16'd12;
        step();
        li_lastMB_DF = 0;
        chk("t5_overlap", err[2], 1);
        mi_ack = 1;
        repeat (4) step();
        chk("t5_single_pulse", done_seen, 1);
        chk("t5_poc", frame_POC, 16'd11);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            li_we_luma     = ($urandom_range(0, 2) == 0);
            li_we_chroma   = ($urandom_range(0, 3) == 0);
            li_addr_luma   = 20'($urandom);
            li_addr_chroma = 19'($urandom);
            li_data        = $urandom;
            mi_ack         = ($urandom_range(0, 2) != 0);
            li_POC         = 16'($urandom);
            if ($urandom_range(0, 11) == 0) li_lastMB_DF = ~li_lastMB_DF;
            step();
        end
        no_write();
        li_lastMB_DF = 0;
        mi_ack = 1;
        for (int i = 0; i < 60 && (q.size() != 0 || m_drain); i++) step();
        chk("rand_drained", busy, 0);

        // Asynchronous reset mid-drain
        mi_ack = 0;
        for (int i = 0; i < 6; i++) begin
            luma(20'(i + 32'h400), 32'(32'hBEEF0000 + i));
            step();
        end
        no_write();
        li_lastMB_DF = 1; li_POC = 16'd21;
        step();
        li_lastMB_DF = 0;
        #2;
        reset_n = 0;
        #1;
        model_reset();
        check_all();
        chk("t6_addr", mo_addr, 0);
        chk("t6_data", mo_data, 0);
        chk("t6_level", fifo_level, 0);
        step();
        reset_n = 1;
        mi_ack = 1;
        done_seen = 0;
        repeat (6) step();
        chk("t6_no_req", mo_req, 0);
        chk("t6_no_done", done_seen, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
